ifetch: RTL and testbench

Instruction fetch stage for the SISC processor. It holds the fetch program counter and issues word reads to instruction memory over a req/ack handshake. Returned words are buffered in a small prefetch FIFO, and the FIFO head is presented as `ir` (with `pc` and `ir_valid`) to the execute core that decodes `ir[31:28]`. Branches from control flush the buffer and redirect fetch.

---
 rtl/ifetch.sv | 137 +++++++++++++
 tb/tb_ifetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ifetch: SISC fetch stage -- fetch PC, single-outstanding imem req/ack, prefetch FIFO, branch flush.
// Define IFETCH_HALT_EN to stop fetching after an HLT word (ir[31:28] == 4'hF) is buffered.
module ifetch #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              ir_take,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              halted
);

  // Handshakes: imem_req/imem_addr rise together and hold until an edge where imem_ack is high;
  // an ack while imem_req is low is ignored. ir/pc transfer on every edge where ir_valid && ir_take.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fpc, fpc_next, fpc_inc, req_addr, req_addr_next;
  logic [31:0]       fifo_word [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_next;
  logic              push, pop, room, run, hlt_push, halted_q;

  assign push       = (state == REQ) && imem_ack && !br_taken;
  assign pop        = ir_take && ir_valid && !br_taken;
  assign count_next = count + CW'(push) - CW'(pop);
  assign room       = count_next < CW'(DEPTH);
  assign fpc_inc    = fpc + ADDR_W'(1);

  assign imem_req  = (state != IDLE);
  assign imem_addr = req_addr;
  assign ir_valid  = (count != '0);
  assign ir        = ir_valid ? fifo_word[rd_ptr] : 32'h0;
  assign pc        = ir_valid ? fifo_addr[rd_ptr] : '0;

`ifdef IFETCH_HALT_EN
  assign hlt_push = push && (imem_data[31:28] == 4'hF);

  always_ff @(posedge clk) begin
    if (rst_f)         halted_q <= 1'b0;
    else if (br_taken) halted_q <= 1'b0;
    else if (hlt_push) halted_q <= 1'b1;
  end
`else
  assign hlt_push = 1'b0;
  assign halted_q = 1'b0;
`endif

  assign halted = halted_q;

  always_comb begin
    state_next    = state;
    fpc_next      = fpc;
    req_addr_next = req_addr;
    if (br_taken) begin
      fpc_next = br_target;
      // An unacked request cannot be withdrawn, so it is drained in DROP first.
      if (state == IDLE || imem_ack) begin
        state_next    = REQ;
        req_addr_next = br_target;
      end else begin
        state_next = DROP;
      end
    end else begin
      case (state)
        IDLE: begin
          if (run && !halted_q && room) begin
            state_next    = REQ;
            req_addr_next = fpc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fpc_next = fpc_inc;
            if (room && !hlt_push) req_addr_next = fpc_inc;
            else                   state_next    = IDLE;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_next    = REQ;
            req_addr_next = fpc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // run holds fetch off for the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state    <= IDLE;
      fpc      <= '0;
      req_addr <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      run      <= 1'b0;
    end else begin
      state    <= state_next;
      fpc      <= fpc_next;
      req_addr <= req_addr_next;
      run      <= 1'b1;
      if (br_taken) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_next;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word[wr_ptr] <= imem_data;
      fifo_addr[wr_ptr] <= req_addr;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed scenarios plus a randomized run checked against an in-order PC stream model.
module tb_ifetch;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_f = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_data = 32'h0;
  logic              br_taken = 1'b0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              ir_take = 1'b0;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic              ir_valid;
  logic              halted;

  int tests_run = 0;
  int tests_failed = 0;

  logic              mem_en = 1'b0;
  logic              force_ack = 1'b0;
  int                mem_lat = 0;
  int                wait_cnt = 0;
  logic              hlt_en = 1'b0;
  logic [ADDR_W-1:0] hlt_addr = '0;
  logic              ack_taken = 1'b0;
  logic [ADDR_W-1:0] ack_addr_q[$];
  logic [31:0]       exp_q[$];

  ifetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_f(rst_f), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .br_taken(br_taken), .br_target(br_target),
    .ir_take(ir_take), .ir(ir), .pc(pc), .ir_valid(ir_valid), .halted(halted)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_f = 1'b1; br_taken = 1'b0; force_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_f = 1'b0;
    ack_addr_q.delete();
  endtask

  // ---------------- memory model ----------------
  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    if (hlt_en && a == hlt_addr) return 32'hF000_0000;
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Responds shortly after each rising edge so the reply is set up well before the next one.
  always begin
    @(posedge clk);
    #2;
    if (force_ack) begin
      imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    end else if (mem_en && imem_req) begin
      if (wait_cnt >= mem_lat) begin
        imem_ack = 1'b1; imem_data = word_of(imem_addr); wait_cnt = 0;
      end else begin
        imem_ack = 1'b0; imem_data = 32'h0; wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0; wait_cnt = 0;
    end
  end

  always @(posedge clk) begin
    ack_taken = imem_req && imem_ack && !rst_f;
    if (ack_taken) ack_addr_q.push_back(imem_addr);
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem_en = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", ir_valid); end
    tests_run++; if (ir !== 32'h0) begin tests_failed++; $display("FAIL reset_ir: got %h want 0", ir); end
    tests_run++; if (pc !== '0) begin tests_failed++; $display("FAIL reset_pc: got %h want 0", pc); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %0b want 0", halted); end
    rst_f = 1'b0;
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL first_req_idle: got %0b want 0", imem_req); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== '0) begin tests_failed++; $display("FAIL first_req: req %0b addr %h want 1 0000", imem_req, imem_addr); end
    // Abandon the request by reset, then present a stray ack while no request is up.
    rst_f = 1'b1; force_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    force_ack = 1'b0;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL abandon_req: got %0b want 0", imem_req); end
    repeat (3) @(negedge clk);
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL stray_ack: ir_valid %0b want 0", ir_valid); end
  endtask

  task automatic test_stream();
    mem_en = 1'b1; mem_lat = 0; ir_take = 1'b1;
    do_reset();
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_n: req %0b valid %0b want 0 0", imem_req, ir_valid); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || ir_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_n1: req %0b valid %0b want 1 0", imem_req, ir_valid); end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h1000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (ir_valid !== 1'b1 || ir !== exp_q[i] || pc !== ADDR_W'(i) || imem_req !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_%0d: valid %0b ir %h pc %h req %0b want 1 %h %h 1", i, ir_valid, ir, pc, imem_req, exp_q[i], i);
      end
    end
  endtask

  task automatic test_full();
    mem_en = 1'b1; mem_lat = 0; ir_take = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    tests_run++; if (ack_addr_q.size() != DEPTH) begin tests_failed++; $display("FAIL full_acks: got %0d want %0d", ack_addr_q.size(), DEPTH); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL full_req: got %0b want 0", imem_req); end
    tests_run++; if (ir !== word_of(0) || pc !== '0) begin tests_failed++; $display("FAIL full_head: ir %h pc %h want %h 0000", ir, pc, word_of(0)); end
    ir_take = 1'b1;
    @(negedge clk);
    ir_take = 1'b0;
    tests_run++; if (ir !== word_of(1) || pc !== 16'd1) begin tests_failed++; $display("FAIL full_pop: ir %h pc %h want %h 0001", ir, pc, word_of(1)); end
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'd2) begin tests_failed++; $display("FAIL full_refill: req %0b addr %h want 1 0002", imem_req, imem_addr); end
    repeat (3) @(negedge clk);
    tests_run++; if (ack_addr_q.size() != 3 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL full_again: acks %0d req %0b want 3 0", ack_addr_q.size(), imem_req); end
  endtask

  task automatic test_branch_wait();
    bit got;
    mem_en = 1'b1; mem_lat = 3; ir_take = 1'b1;
    do_reset();
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = imem_req; end
    tests_run++; if (!got) begin tests_failed++; $display("FAIL bw_req_timeout: no request within 10 cycles"); end
    br_taken = 1'b1; br_target = 16'h0040;
    @(negedge clk);
    br_taken = 1'b0;
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== '0) begin tests_failed++; $display("FAIL bw_hold: req %0b addr %h want 1 0000", imem_req, imem_addr); end
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = ir_valid;
      if (!got && imem_req && ack_addr_q.size() == 0) begin
        tests_run++; if (imem_addr !== '0) begin tests_failed++; $display("FAIL bw_addr_stable: got %h want 0000", imem_addr); end
      end
    end
    tests_run++; if (!got) begin tests_failed++; $display("FAIL bw_valid_timeout: no ir_valid within 30 cycles"); end
    tests_run++; if (pc !== 16'h0040 || ir !== word_of(16'h0040)) begin tests_failed++; $display("FAIL bw_first: pc %h ir %h want 0040 %h", pc, ir, word_of(16'h0040)); end
    tests_run++;
    if (ack_addr_q.size() < 2 || ack_addr_q[0] !== '0 || ack_addr_q[1] !== 16'h0040) begin
      tests_failed++; $display("FAIL bw_ack_order: size %0d want acks at 0000 then 0040", ack_addr_q.size());
    end
  endtask

  task automatic test_same_cycle();
    mem_en = 1'b1; mem_lat = 0; ir_take = 1'b1;
    do_reset();
    repeat (5) @(negedge clk);
    tests_run++; if (ir_valid !== 1'b1 || imem_ack !== 1'b1) begin tests_failed++; $display("FAIL sc_pre: valid %0b ack %0b want 1 1", ir_valid, imem_ack); end
    br_taken = 1'b1; br_target = 16'h0123;
    @(negedge clk);
    br_taken = 1'b0;
    tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL sc_flush: valid %0b want 0", ir_valid); end
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0123) begin tests_failed++; $display("FAIL sc_redirect: req %0b addr %h want 1 0123", imem_req, imem_addr); end
    @(negedge clk);
    tests_run++; if (ir_valid !== 1'b1 || pc !== 16'h0123 || ir !== word_of(16'h0123)) begin tests_failed++; $display("FAIL sc_first: valid %0b pc %h ir %h want 1 0123 %h", ir_valid, pc, ir, word_of(16'h0123)); end
  endtask

  task automatic test_wrap();
    mem_en = 1'b1; mem_lat = 0; ir_take = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    br_taken = 1'b1; br_target = 16'hFFFF;
    @(negedge clk);
    br_taken = 1'b0;
    @(negedge clk);
    tests_run++; if (ir_valid !== 1'b1 || pc !== 16'hFFFF || ir !== 32'h1000_FFFF) begin tests_failed++; $display("FAIL wrap_ffff: valid %0b pc %h ir %h want 1 ffff 1000ffff", ir_valid, pc, ir); end
    @(negedge clk);
    tests_run++; if (ir_valid !== 1'b1 || pc !== 16'h0000 || ir !== 32'h1000_0000) begin tests_failed++; $display("FAIL wrap_0000: valid %0b pc %h ir %h want 1 0000 10000000", ir_valid, pc, ir); end
  endtask

  task automatic test_hlt();
    bit seen3, saw4;
    mem_en = 1'b1; mem_lat = 0; ir_take = 1'b1; hlt_en = 1'b1; hlt_addr = 16'd3;
    do_reset();
    seen3 = 0; saw4 = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (ir_valid && pc == 16'd3 && !seen3) begin
        seen3 = 1;
        tests_run++; if (ir !== 32'hF000_0000) begin tests_failed++; $display("FAIL hlt_word: got %h want f0000000", ir); end
`ifdef IFETCH_HALT_EN
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL hlt_set: got %0b want 1", halted); end
`else
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL hlt_tied: got %0b want 0", halted); end
`endif
      end
    end
    foreach (ack_addr_q[k]) if (ack_addr_q[k] == 16'd4) saw4 = 1;
    tests_run++; if (!seen3) begin tests_failed++; $display("FAIL hlt_seen: HLT word at pc 0003 never presented"); end
`ifdef IFETCH_HALT_EN
    tests_run++; if (saw4) begin tests_failed++; $display("FAIL hlt_stop: got request to 0004 want none"); end
    tests_run++; if (halted !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0) begin tests_failed++; $display("FAIL hlt_drained: halted %0b req %0b valid %0b want 1 0 0", halted, imem_req, ir_valid); end
    br_taken = 1'b1; br_target = 16'd0;
    @(negedge clk);
    br_taken = 1'b0;
    tests_run++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== '0) begin tests_failed++; $display("FAIL hlt_resume: halted %0b req %0b addr %h want 0 1 0000", halted, imem_req, imem_addr); end
`else
    tests_run++; if (!saw4) begin tests_failed++; $display("FAIL hlt_continue: no request to 0004 after HLT word"); end
    tests_run++; if (halted !== 1'b0 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL hlt_running: halted %0b req %0b want 0 1", halted, imem_req); end
`endif
    hlt_en = 1'b0;
  endtask

  // Reference: the core must see one contiguous address stream, restarting at each branch target,
  // with every word equal to the memory contents at its address.
  task automatic test_random();
    logic [ADDR_W-1:0] exp_pc, prev_addr;
    bit prev_req, br;
    int streak, max_streak;
    mem_en = 1'b1; mem_lat = 0; ir_take = 1'b0;
    do_reset();
    exp_pc = '0; prev_req = 0; prev_addr = '0; streak = 0; max_streak = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (ir_valid) begin
        tests_run++; if (pc !== exp_pc) begin tests_failed++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, pc, exp_pc); end
        tests_run++; if (ir !== word_of(exp_pc)) begin tests_failed++; $display("FAIL rnd_ir@%0d: got %h want %h", cyc, ir, word_of(exp_pc)); end
      end
      if (prev_req && !ack_taken) begin
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          tests_failed++; $display("FAIL rnd_hold@%0d: req %0b addr %h want 1 %h", cyc, imem_req, imem_addr, prev_addr);
        end
      end
      prev_req = imem_req; prev_addr = imem_addr;
      if (cyc % 64 == 0) mem_lat = $urandom_range(0, 3);
      ir_take = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 19) == 0);
      br_taken = br;
      br_target = ADDR_W'($urandom);
      streak = (br || ir_valid) ? 0 : streak + 1;
      if (streak > max_streak) max_streak = streak;
      if (br) exp_pc = br_target;
      else if (ir_take && ir_valid) exp_pc = exp_pc + ADDR_W'(1);
    end
    @(negedge clk);
    br_taken = 1'b0; ir_take = 1'b0;
    tests_run++; if (max_streak > 20) begin tests_failed++; $display("FAIL rnd_starve: empty for %0d cycles want <= 20", max_streak); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_branch_wait();
    test_same_cycle();
    test_wrap();
    test_hlt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
